sa_operand_feeder: RTL

Edge driver for the N x N systolic FP32 multiplier array. It buffers matrix A (N x K) and matrix B (K x N), then streams them into the array's left and top edges with diagonal skew. Row i of A and column j of B are delayed i and j cycles, with +0.0 padding. It also pulses an accumulator-clear to the PEs before each run and signals completion after the wavefront has drained.

---
 rtl/sa_operand_feeder.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/sa_operand_feeder.sv
// ---------------------------------------------------------------------------
// sa_operand_feeder
//
// Edge driver for an N x N systolic FP32 multiplier array. Matrix A (N x K)
// and matrix B (K x N) are loaded into local buffers while idle, then a run
// streams them into the array with a diagonal skew. Row i of A enters on the
// left edge delayed by i cycles, and column j of B enters on the top edge
// delayed by j cycles. Lanes outside their window carry +0.0.
//
// Run sequence:
//   IDLE -> CLEAR  (1 cycle, acc_clr pulse)
//        -> STREAM (N+K-1 cycles, out_valid high)
//        -> DRAIN  (N-1+PE_LAT cycles, wavefront leaves the array)
//        -> DONE   (1 cycle, done pulse)
//        -> IDLE
// Operands pass through bit-exact; no FP arithmetic is done here.
//
// Optional feature (macro FEEDER_AUTO_START_EN):
//   When defined, an accepted write to the last B element (wr_sel=1,
//   wr_addr=K*N-1) also starts a run in the same cycle. When undefined,
//   only start begins a run.
//
// Ports:
//   clk        in   clock, all state on the rising edge
//   rst_n      in   asynchronous active-low reset
//   wr_en      in   buffer write strobe (honoured only in IDLE)
//   wr_sel     in   0 = matrix A, 1 = matrix B
//   wr_addr    in   row-major element index (A: i*K+k, B: k*N+j)
//   wr_data    in   FP32 element
//   start      in   run request, single-cycle pulse (honoured only in IDLE)
//   busy       out  high from CLEAR through DRAIN
//   done       out  one-cycle pulse at end of run
//   acc_clr    out  one-cycle accumulator clear to all PEs
//   out_valid  out  high during STREAM
//   out_left   out  left-edge operand for row i in bits [i*DW +: DW]
//   out_top    out  top-edge operand for column j in bits [j*DW +: DW]
// ---------------------------------------------------------------------------
module sa_operand_feeder #(
  parameter int N      = 4,
  parameter int K      = 4,
  parameter int DW     = 32,
  parameter int PE_LAT = 1,
  localparam int AW    = $clog2(N*K)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wr_en,
  input  logic            wr_sel,
  input  logic [AW-1:0]   wr_addr,
  input  logic [DW-1:0]   wr_data,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic            acc_clr,
  output logic            out_valid,
  output logic [N*DW-1:0] out_left,
  output logic [N*DW-1:0] out_top
);

  localparam int DEPTH      = N * K;
  localparam int STREAM_LEN = N + K - 1;
  localparam int DRAIN_LEN  = N - 1 + PE_LAT;
  // One counter runs across STREAM and DRAIN, so it must hold the last
  // DRAIN index without wrapping.
  localparam int CW         = $clog2(N + K + N + PE_LAT + 1);

  localparam logic [CW-1:0] STREAM_LAST = CW'(STREAM_LEN - 1);
  localparam logic [CW-1:0] RUN_LAST    = CW'(STREAM_LEN - 1 + DRAIN_LEN);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t        state;
  logic [CW-1:0] t;

  logic [DW-1:0] a_mem [DEPTH];
  logic [DW-1:0] b_mem [DEPTH];

  logic in_range;
  logic wr_ok;
  logic auto_start;
  logic run_req;

  assign in_range = ({1'b0, wr_addr} < (AW+1)'(DEPTH));
  assign wr_ok    = (state == S_IDLE) && wr_en && in_range;

`ifdef FEEDER_AUTO_START_EN
  assign auto_start = wr_ok && wr_sel && (wr_addr == AW'(DEPTH - 1));
`else
  assign auto_start = 1'b0;
`endif

  // A write in the same cycle as the run request lands in the buffer on that
  // edge; the first operand read happens one edge later, so it sees the
  // new word.
  assign run_req = (state == S_IDLE) && (start || auto_start);

  // -------------------------------------------------------------------------
  // Operand buffers
  // -------------------------------------------------------------------------
  // NOTE: the buffers are explicitly cleared on reset so a run after reset
  // streams +0.0 rather than undefined data; this makes them flops, not RAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int e = 0; e < DEPTH; e++) begin
        a_mem[e] <= '0;
        b_mem[e] <= '0;
      end
    end else if (wr_ok) begin
      if (wr_sel) b_mem[wr_addr] <= wr_data;
      else        a_mem[wr_addr] <= wr_data;
    end
  end

  // -------------------------------------------------------------------------
  // Skewed lane selection for stream step tt.
  // Left lane i carries A[i][tt-i]; top lane j carries B[tt-j][j].
  // -------------------------------------------------------------------------
  function automatic logic [N*DW-1:0] left_lanes(input int tt);
    logic [N*DW-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++) begin
      if ((tt - i >= 0) && (tt - i < K))
        v[i*DW +: DW] = a_mem[i*K + (tt - i)];
    end
    return v;
  endfunction

  function automatic logic [N*DW-1:0] top_lanes(input int tt);
    logic [N*DW-1:0] v;
    v = '0;
    for (int j = 0; j < N; j++) begin
      if ((tt - j >= 0) && (tt - j < K))
        v[j*DW +: DW] = b_mem[(tt - j)*N + j];
    end
    return v;
  endfunction

  // -------------------------------------------------------------------------
  // Run sequencer with registered outputs
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      t         <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      acc_clr   <= 1'b0;
      out_valid <= 1'b0;
      out_left  <= '0;
      out_top   <= '0;
    end else begin
      // NOTE: non-blocking defaults first; each state overrides only the
      // outputs it raises, so pulses and buses fall back to 0 on their own.
      done      <= 1'b0;
      acc_clr   <= 1'b0;
      out_valid <= 1'b0;
      out_left  <= '0;
      out_top   <= '0;

      case (state)
        S_IDLE: begin
          t <= '0;
          if (run_req) begin
            state   <= S_CLEAR;
            busy    <= 1'b1;
            acc_clr <= 1'b1;
          end
        end

        S_CLEAR: begin
          state     <= S_STREAM;
          t         <= '0;
          out_valid <= 1'b1;
          out_left  <= left_lanes(0);
          out_top   <= top_lanes(0);
        end

        S_STREAM: begin
          t <= t + 1'b1;
          if (t == STREAM_LAST) begin
            if (DRAIN_LEN == 0) begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state <= S_DRAIN;
            end
          end else begin
            // Outputs are registered, so load the lanes for the next step.
            out_valid <= 1'b1;
            out_left  <= left_lanes(int'(t) + 1);
            out_top   <= top_lanes(int'(t) + 1);
          end
        end

        S_DRAIN: begin
          if (t == RUN_LAST) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            t <= t + 1'b1;
          end
        end

        S_DONE: begin
          state <= S_IDLE;
          t     <= '0;
        end

        default: begin
          state <= S_IDLE;
          t     <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
